// File: rtl/day_counter_if.sv
// Date-stage bus: day tick, key levels, screen/edit context and month info in,
// current day and month carry out.
interface day_counter_if;
   logic       ClkDay;
   logic       KeyPlus;
   logic       KeyMinus;
   logic       EditMode;
   logic [2:0] EditPos;
   logic [1:0] screen;
   logic [3:0] month;
   logic       leap;
   logic [4:0] days;
   logic       ClkMonth;

   modport slave (
      input  ClkDay, KeyPlus, KeyMinus, EditMode, EditPos, screen, month, leap,
      output days, ClkMonth
   );

   modport master (
      output ClkDay, KeyPlus, KeyMinus, EditMode, EditPos, screen, month, leap,
      input  days, ClkMonth
   );
endinterface

// File: rtl/day_counter.sv
// Day-of-month counter: advances on the day tick, emits the month carry,
// supports digit-wise key editing and clamps to the current month length.
module day_counter (
   input  logic         clk,
   input  logic         reset,
   day_counter_if.slave dc
);
   localparam int unsigned DAY_W = 5;
   localparam int unsigned AW    = 6;

   typedef enum logic [2:0] {
      P_NONE,
      P_U_INC,
      P_U_DEC,
      P_T_INC,
      P_T_DEC
   } op_e;

   op_e              op_q, op_d;
   logic [DAY_W-1:0] days_q, days_d;
   logic             clk_month_q, clk_month_d;

   logic [AW-1:0] d, m, d_mod10, t_inc, t_dec;
   logic          edit_ok, pos_units;

   assign d         = {1'b0, days_q};
   assign pos_units = (dc.EditPos == 3'd5);
   assign edit_ok   = dc.EditMode && (dc.screen == 2'd1) &&
                      ((dc.EditPos == 3'd5) || (dc.EditPos == 3'd4));

   // Length of the current month; out-of-range month codes read as 31.
   always_comb begin
      m = AW'(31);
      case (dc.month)
         4'd2:                      m = dc.leap ? AW'(29) : AW'(28);
         4'd4, 4'd6, 4'd9, 4'd11:   m = AW'(30);
         default:                   m = AW'(31);
      endcase
   end

   // Tens-digit edit results; the units digit is kept when tens wrap.
   always_comb begin
      d_mod10 = d;
      if (d >= AW'(30))      d_mod10 = d - AW'(30);
      else if (d >= AW'(20)) d_mod10 = d - AW'(20);
      else if (d >= AW'(10)) d_mod10 = d - AW'(10);

      t_inc = AW'(10);
      if (d + AW'(10) <= m)        t_inc = d + AW'(10);
      else if (d_mod10 != AW'(0))  t_inc = d_mod10;

      t_dec = d + AW'(10);
      if (d > AW'(10))             t_dec = d - AW'(10);
      else if (d + AW'(30) <= m)   t_dec = d + AW'(30);
      else if (d + AW'(20) <= m)   t_dec = d + AW'(20);
   end

   // Next pending op, next day and month carry.
   always_comb begin
      op_d        = op_q;
      days_d      = days_q;
      clk_month_d = 1'b0;

      if (dc.ClkDay) begin
         op_d = P_NONE;
         if (!dc.EditMode) begin
            if (d >= m) begin
               days_d      = DAY_W'(1);
               clk_month_d = 1'b1;
            end else begin
               days_d = DAY_W'(d + AW'(1));
            end
         end
      end else if (!dc.KeyPlus) begin
         op_d = edit_ok ? (pos_units ? P_U_INC : P_T_INC) : P_NONE;
      end else if (!dc.KeyMinus) begin
         op_d = edit_ok ? (pos_units ? P_U_DEC : P_T_DEC) : P_NONE;
      end else begin
         op_d = P_NONE;
         case (op_q)
            P_U_INC: days_d = (d >= m) ? DAY_W'(1) : DAY_W'(d + AW'(1));
            P_U_DEC: days_d = (d == AW'(1)) ? DAY_W'(m) : DAY_W'(d - AW'(1));
            P_T_INC: days_d = DAY_W'(t_inc);
            P_T_DEC: days_d = DAY_W'(t_dec);
            default: if (d > m) days_d = DAY_W'(m);
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q        <= P_NONE;
         days_q      <= DAY_W'(1);
         clk_month_q <= 1'b0;
      end else begin
         op_q        <= op_d;
         days_q      <= days_d;
         clk_month_q <= clk_month_d;
      end
   end

   assign dc.days     = days_q;
   assign dc.ClkMonth = clk_month_q;

endmodule

// File: tb/tb_day_counter.sv
// Directed bench for day_counter: expected day/carry pairs are queued as
// stimulus is applied and popped when the outputs are sampled.
module tb_day_counter;
   logic clk;
   logic reset;

   day_counter_if dc ();

   day_counter u_dut (
      .clk   (clk),
      .reset (reset),
      .dc    (dc)
   );

   typedef struct {
      logic [4:0] d;
      logic       cm;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      dc.ClkDay = 1'b1;
      step();
      dc.ClkDay = 1'b0;
   endtask

   task automatic push(input int d, input logic cm);
      exp_t e;
      e.d  = 5'(d);
      e.cm = cm;
      exp_q.push_back(e);
   endtask

   task automatic check(input string tag);
      exp_t e;
      n_assert++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: no expected entry queued (days observed %0d)", tag, dc.days);
         return;
      end
      e = exp_q.pop_front();
      assert (dc.days === e.d) else begin
         n_fail++;
         $error("FAIL %s: days observed %0d expected %0d", tag, dc.days, e.d);
      end
      n_assert++;
      assert (dc.ClkMonth === e.cm) else begin
         n_fail++;
         $error("FAIL %s: ClkMonth observed %b expected %b", tag, dc.ClkMonth, e.cm);
      end
   endtask

   task automatic expect_now(input int d, input logic cm, input string tag);
      push(d, cm);
      check(tag);
   endtask

   // Reset, then count up in run mode from 1 with a 31-day month.
   task automatic set_days(input int n);
      reset = 1'b1;
      #1;
      reset       = 1'b0;
      dc.EditMode = 1'b0;
      dc.KeyPlus  = 1'b1;
      dc.KeyMinus = 1'b1;
      dc.ClkDay   = 1'b0;
      dc.month    = 4'd1;
      repeat (n - 1) tick();
   endtask

   task automatic edit_on(input int pos);
      dc.EditMode = 1'b1;
      dc.screen   = 2'd1;
      dc.EditPos  = 3'(pos);
   endtask

   task automatic press_plus(input int cycles);
      dc.KeyPlus = 1'b0;
      repeat (cycles) step();
      dc.KeyPlus = 1'b1;
      step();
   endtask

   task automatic press_minus(input int cycles);
      dc.KeyMinus = 1'b0;
      repeat (cycles) step();
      dc.KeyMinus = 1'b1;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      dc.ClkDay   = 1'b0;
      dc.KeyPlus  = 1'b1;
      dc.KeyMinus = 1'b1;
      dc.EditMode = 1'b0;
      dc.EditPos  = 3'd0;
      dc.screen   = 2'd0;
      dc.month    = 4'd1;
      dc.leap     = 1'b0;
      repeat (2) step();
      expect_now(1, 1'b0, "reset_state");
      reset = 1'b0;

      // Reset mid-press clears the pending edit
      set_days(7);
      expect_now(7, 1'b0, "preset_7");
      edit_on(5);
      dc.KeyPlus = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      #1;
      expect_now(1, 1'b0, "async_reset");
      dc.KeyPlus = 1'b1;
      step();
      reset = 1'b0;
      repeat (2) step();
      expect_now(1, 1'b0, "no_commit_after_reset");

      // Month rollover
      set_days(31);
      expect_now(31, 1'b0, "preset_31");
      tick();
      expect_now(1, 1'b1, "wrap_jan");
      step();
      expect_now(1, 1'b0, "carry_one_cycle");
      set_days(30);
      tick();
      expect_now(31, 1'b0, "jan_30_to_31");

      // February in leap and common years
      set_days(28);
      dc.month = 4'd2;
      dc.leap  = 1'b1;
      tick();
      expect_now(29, 1'b0, "feb_leap_29");
      tick();
      expect_now(1, 1'b1, "feb_leap_wrap");
      set_days(28);
      dc.month = 4'd2;
      dc.leap  = 1'b0;
      tick();
      expect_now(1, 1'b1, "feb_common_wrap");
      step();
      expect_now(1, 1'b0, "feb_carry_drop");

      // Back-to-back ticks across a wrap
      set_days(30);
      dc.ClkDay = 1'b1;
      step();
      expect_now(31, 1'b0, "b2b_first");
      step();
      expect_now(1, 1'b1, "b2b_wrap");
      step();
      dc.ClkDay = 1'b0;
      expect_now(2, 1'b0, "b2b_after_wrap");

      // Units digit editing
      set_days(31);
      edit_on(5);
      dc.KeyPlus = 1'b0;
      step();
      expect_now(31, 1'b0, "units_held");
      dc.KeyPlus = 1'b1;
      step();
      expect_now(1, 1'b0, "units_inc_wrap");
      press_minus(1);
      expect_now(31, 1'b0, "units_dec_wrap");
      press_plus(5);
      expect_now(1, 1'b0, "units_hold5");
      step();
      expect_now(1, 1'b0, "units_no_repeat");
      dc.KeyPlus  = 1'b0;
      dc.KeyMinus = 1'b0;
      step();
      dc.KeyPlus  = 1'b1;
      dc.KeyMinus = 1'b1;
      step();
      expect_now(2, 1'b0, "plus_wins");
      dc.EditPos = 3'd3;
      press_plus(1);
      expect_now(2, 1'b0, "pos_not_edited");

      // Tens digit editing
      set_days(5);
      dc.month = 4'd2;
      dc.leap  = 1'b0;
      edit_on(4);
      press_minus(1);
      expect_now(25, 1'b0, "tens_dec_feb");
      press_plus(1);
      expect_now(5, 1'b0, "tens_inc_feb");
      set_days(30);
      edit_on(4);
      press_plus(1);
      expect_now(10, 1'b0, "tens_inc_30");
      press_minus(1);
      expect_now(30, 1'b0, "tens_dec_10");
      press_minus(1);
      expect_now(20, 1'b0, "tens_dec_30");

      // Clamp on month change, then tick cancels a held edit
      set_days(31);
      dc.month = 4'd4;
      step();
      expect_now(30, 1'b0, "clamp_apr");
      edit_on(5);
      dc.KeyPlus = 1'b0;
      step();
      dc.ClkDay = 1'b1;
      step();
      dc.ClkDay  = 1'b0;
      dc.KeyPlus = 1'b1;
      repeat (2) step();
      expect_now(30, 1'b0, "tick_cancels_edit");

      if (exp_q.size() != 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/day_counter.md
# day_counter

Day-of-month counter for the clock/calendar datapath. Advances on the one-cycle day tick from the hour stage and emits the one-cycle month carry consumed by the month counter. Supports digit-wise manual editing via the Plus/Minus keys on the date screen. Clamps the day to the length of the current month, including February in leap years.

## Interface
Parameters: none.

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- ClkDay  in  1  day tick, one-cycle pulse, synchronous to clk
- KeyPlus  in  1  Plus key, active-low, debounced level
- KeyMinus  in  1  Minus key, active-low, debounced level
- EditMode  in  1  1 = edit mode, 0 = run mode
- EditPos  in  3  edited digit: 5 = day units, 4 = day tens
- screen  in  2  active screen; 1 = date screen
- month  in  4  current month, binary 1–12
- leap  in  1  1 = current year is a leap year
- days  out  5  current day, binary 1–31
- ClkMonth  out  1  month carry, one-cycle registered pulse

## Operation
- max(month): Feb = 29 if leap, else 28; Apr/Jun/Sep/Nov = 30; all others, including out-of-range 0 and 13–15, = 31.
- Edit condition E: EditMode==1 && screen==1 && (EditPos==5 || EditPos==4).
- Internal pending op P: NONE, U_INC, U_DEC, T_INC, T_DEC.
- Per-cycle priority, highest first:
  1. reset: days=1, ClkMonth=0, P=NONE.
  2. ClkDay=1:
     - Run mode: if days>=max, days=1 and ClkMonth=1 next cycle; else days+1.
     - Edit mode: days unchanged.
     - Either mode: P=NONE.
  3. KeyPlus=0: P = E ? (pos5 ? U_INC : T_INC) : NONE. Plus wins when both keys are low.
  4. KeyMinus=0: P = E ? (pos5 ? U_DEC : T_DEC) : NONE.
  5. Idle cycle (both keys high, no tick): apply P, then P=NONE.
- Commit occurs exactly once per press, on the first idle cycle after release. P is re-evaluated every low cycle, so a release while E is false commits nothing.
- Apply rules, with d = days and m = max:
  - U_INC: d==m ? 1 : d+1
  - U_DEC: d==1 ? m : d-1
  - T_INC: d+10<=m ? d+10 : (d%10==0 ? 10 : d%10)
  - T_DEC: d>10 ? d-10 : first of d+30, d+20, d+10 that is <=m
- Clamp: on an idle cycle with P==NONE and days>m (month or leap changed), days=m. No ClkMonth is emitted.
- ClkMonth is asserted only by a run-mode ClkDay wrap; never by edits or clamps.
- Width rule: all arithmetic is 6-bit internally; days never leaves 1..31.

## Timing
- Reset values: days=1, ClkMonth=0, P=NONE; takes effect immediately and asynchronously.
- Reset asserted mid-press: P is cleared, so no commit occurs after reset deassertion, even if the key is still low and later released.
- Tick latency: days updates on the clk edge sampling ClkDay=1. ClkMonth is high for exactly the following cycle, aligned with days==1.
- Edit latency: days changes on the edge of the first cycle with both keys high. Holding a key does not auto-repeat.
- ClkDay arriving while a key is held cancels the pending edit. A subsequent release commits nothing unless the key is sampled low again.
- Back-to-back ClkDay pulses on consecutive cycles each advance days by one. Two wraps produce two distinct one-cycle ClkMonth pulses.
- Clamp latency: one idle cycle after month/leap changes.

## Test plan
- Reset mid-operation: hold KeyPlus low in edit (pos5, days=7), pulse reset, release key -> days=1, P cleared, no commit, ClkMonth=0.
- Month rollover: month=1, days=31, run mode, ClkDay pulse -> days=1, ClkMonth=1 for exactly one cycle. Repeat at days=30 -> days=31, ClkMonth=0.
- February length: month=2, leap=1, days=28, tick -> 29; tick again -> 1 with ClkMonth. With leap=0, days=28, tick -> 1 with ClkMonth.
- Units edit: month=1, days=31, EditMode=1, screen=1, EditPos=5, press/release KeyPlus -> days=1. KeyMinus from 1 -> 31. Hold 5 cycles -> exactly one change.
- Tens edit: month=2, leap=0, days=5, EditPos=4, KeyMinus -> 25. From 25, KeyPlus -> 5. month=1, days=30, KeyPlus -> 10.
- Clamp and cancel: days=31, month changes 1->4 -> days=30 next idle cycle. Hold KeyPlus (edit, pos5), assert ClkDay, release -> days unchanged.
